// File: rtl/surf_cin_decoder.sv
// SURF CIN receiver: aligns the 4-bit ISERDES nibble stream to 32-bit command
// words by hunting for the training word, slipping the ISERDES when it is not found.
module surf_cin_decoder #(
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter int          LOCK_COUNT     = 8,
  parameter int          BITSLIP_WAIT   = 3,
  parameter int          HUNT_LIMIT     = 16
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic [3:0]  cin_data_i,
  input  logic        relock_i,
  output logic        bitslip_o,
  output logic        locked_o,
  output logic [31:0] command_o,
  output logic        command_valid_o,
  output logic        train_o,
  output logic        sync_o,
  output logic [2:0]  bitslip_count_o
);

  typedef enum logic [1:0] {HUNT, SLIPWAIT, VERIFY, LOCKED} state_t;

  localparam logic [7:0] HUNT_LAST = 8'(HUNT_LIMIT - 1);
  localparam logic [3:0] WAIT_LAST = 4'(BITSLIP_WAIT);
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT);

  state_t      state, state_nxt;
  logic [31:0] shreg;
  logic [7:0]  hunt_tmr, hunt_tmr_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [3:0]  match_cnt, match_cnt_nxt;
  logic [2:0]  phase, phase_nxt;
  logic        slip_nxt, locked_nxt, cv_nxt, train_nxt, sync_nxt;
  logic [2:0]  slip_cnt_nxt;
  logic [31:0] command_nxt;
  logic        match;

  assign match = (shreg == TRAIN_SEQUENCE);

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state           <= HUNT;
      shreg           <= '0;
      hunt_tmr        <= '0;
      wait_cnt        <= '0;
      match_cnt       <= '0;
      phase           <= '0;
      bitslip_o       <= 1'b0;
      bitslip_count_o <= '0;
      locked_o        <= 1'b0;
      command_o       <= '0;
      command_valid_o <= 1'b0;
      train_o         <= 1'b0;
      sync_o          <= 1'b0;
    end else begin
      state           <= state_nxt;
      shreg           <= {shreg[27:0], cin_data_i};
      hunt_tmr        <= hunt_tmr_nxt;
      wait_cnt        <= wait_cnt_nxt;
      match_cnt       <= match_cnt_nxt;
      phase           <= phase_nxt;
      bitslip_o       <= slip_nxt;
      bitslip_count_o <= slip_cnt_nxt;
      locked_o        <= locked_nxt;
      command_o       <= command_nxt;
      command_valid_o <= cv_nxt;
      train_o         <= train_nxt;
      sync_o          <= sync_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hunt_tmr_nxt  = hunt_tmr;
    wait_cnt_nxt  = wait_cnt;
    match_cnt_nxt = match_cnt;
    phase_nxt     = phase;
    slip_nxt      = 1'b0;
    slip_cnt_nxt  = bitslip_count_o;
    locked_nxt    = locked_o;
    command_nxt   = command_o;
    cv_nxt        = 1'b0;
    train_nxt     = 1'b0;
    sync_nxt      = 1'b0;

    case (state)
      HUNT: begin
        hunt_tmr_nxt = hunt_tmr + 8'd1;
        if (match) begin
          // this cycle is word boundary 0, so the next one is phase 1
          state_nxt     = VERIFY;
          phase_nxt     = 3'd1;
          match_cnt_nxt = 4'd1;
          hunt_tmr_nxt  = '0;
        end else if (hunt_tmr == HUNT_LAST) begin
          state_nxt    = SLIPWAIT;
          slip_nxt     = 1'b1;
          slip_cnt_nxt = bitslip_count_o + 3'd1;
          hunt_tmr_nxt = '0;
          wait_cnt_nxt = '0;
        end
      end
      SLIPWAIT: begin
        // pulse cycle plus BITSLIP_WAIT idle cycles before hunting again
        if (wait_cnt == WAIT_LAST) begin
          state_nxt    = HUNT;
          hunt_tmr_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      VERIFY: begin
        phase_nxt = phase + 3'd1;
        if (phase == 3'd0) begin
          if (match) begin
            match_cnt_nxt = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_LAST) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end
          end else begin
            state_nxt     = HUNT;
            hunt_tmr_nxt  = '0;
            match_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        phase_nxt = phase + 3'd1;
        if (phase == 3'd0) begin
          sync_nxt = 1'b1;
          if (match) begin
            train_nxt = 1'b1;
          end else begin
            cv_nxt      = 1'b1;
            command_nxt = shreg;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase

    // relock drops everything except the last command word
    if (relock_i) begin
      state_nxt     = HUNT;
      hunt_tmr_nxt  = '0;
      wait_cnt_nxt  = '0;
      match_cnt_nxt = '0;
      phase_nxt     = '0;
      slip_nxt      = 1'b0;
      slip_cnt_nxt  = '0;
      locked_nxt    = 1'b0;
      command_nxt   = command_o;
      cv_nxt        = 1'b0;
      train_nxt     = 1'b0;
      sync_nxt      = 1'b0;
    end
  end

endmodule

// File: tb/tb_surf_cin_decoder.sv
// Bench for surf_cin_decoder: bit-level serial source with an ISERDES bitslip
// model, word scoreboard for strobes/commands, and lock-timing expectations.
module tb_surf_cin_decoder;
  localparam logic [31:0] TRAIN = 32'hA55A6996;

  logic        sysclk = 1'b0;
  logic        rst, relock;
  logic [3:0]  cin;
  logic        bitslip, locked, cmd_valid, train, sync;
  logic [31:0] command;
  logic [2:0]  slip_count;

  always #5 sysclk = ~sysclk;

  surf_cin_decoder dut (
    .sysclk_i(sysclk), .rst_i(rst), .cin_data_i(cin), .relock_i(relock),
    .bitslip_o(bitslip), .locked_o(locked), .command_o(command),
    .command_valid_o(cmd_valid), .train_o(train), .sync_o(sync),
    .bitslip_count_o(slip_count)
  );

  typedef struct { logic [31:0] word; logic chk; logic cv; logic tr; logic [31:0] cmd; } vec_t;
  typedef struct { int cyc; logic cv; logic tr; logic [31:0] cmd; } exp_t;

  vec_t        strm [0:1023];
  vec_t        tab  [10];
  exp_t        exp_q[$];
  int          slip_cyc[$];
  int          cyc, bp, tests, fails, lock_cyc, slips;
  bit          sb_on, lk_on;
  logic [31:0] model_cmd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int first_end(input int c);
    return c + ((7 - (c % 8)) + 8) % 8;
  endfunction

  // serial source: bit 3 of the nibble is the earliest bit; a slip drops one bit
  task automatic drive();
    logic [3:0] n;
    exp_t       e;
    int         w;
    for (int j = 0; j < 4; j++) begin
      w = ((bp + j) / 32) % 1024;
      n[3-j] = strm[w].word[31 - ((bp + j) % 32)];
    end
    cin = n;
    w = (bp / 32) % 1024;
    if (sb_on && ((bp + 4) % 32 == 0) && strm[w].chk) begin
      e.cyc = cyc + 2; e.cv = strm[w].cv; e.tr = strm[w].tr; e.cmd = strm[w].cmd;
      exp_q.push_back(e);
    end
    bp += 4;
    if (bitslip) bp += 1;
  endtask

  task automatic monitor();
    exp_t e;
    if (bitslip) begin slips++; slip_cyc.push_back(cyc); end
    if (lk_on) chk("locked_timing", 32'(locked), 32'(cyc >= lock_cyc));
    if (sb_on) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("word_sync", 32'(sync), 32'd1);
        chk("word_cmd_valid", 32'(cmd_valid), 32'(e.cv));
        chk("word_train", 32'(train), 32'(e.tr));
        chk("word_command", command, e.cmd);
      end else begin
        chk("idle_strobes", 32'({sync, cmd_valid, train}), 32'd0);
      end
    end
  endtask

  task automatic step();
    @(posedge sysclk); #1;
    cyc++;
    monitor();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic fill_train();
    for (int i = 0; i < 1024; i++) begin
      strm[i].word = TRAIN; strm[i].chk = 1'b0; strm[i].cv = 1'b0;
      strm[i].tr = 1'b0; strm[i].cmd = '0;
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_flags"}, 32'({bitslip, locked, cmd_valid, train, sync, slip_count}), 32'd0);
    chk({name, "_command"}, command, 32'd0);
  endtask

  // cycle 0 is the first cycle whose nibble the DUT samples out of reset
  task automatic do_reset(input int bp0);
    rst = 1'b1; relock = 1'b0; cin = '0; sb_on = 1'b0; lk_on = 1'b0;
    exp_q.delete(); slip_cyc.delete(); slips = 0;
    repeat (2) @(posedge sysclk);
    #1;
    cyc = 0; bp = bp0;
    check_zero("reset");
    rst = 1'b0;
    drive();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, t;
    logic [31:0] w;
    tests = 0; fails = 0;
    rst = 1'b1; relock = 1'b0; cin = '0;

    // aligned lock, command table, random traffic, relock, reset mid-verify
    tab[0] = '{TRAIN,        1'b1, 1'b0, 1'b1, 32'h00000000};
    tab[1] = '{TRAIN,        1'b1, 1'b0, 1'b1, 32'h00000000};
    tab[2] = '{32'h12345678, 1'b1, 1'b1, 1'b0, 32'h12345678};
    tab[3] = '{TRAIN,        1'b1, 1'b0, 1'b1, 32'h12345678};
    tab[4] = '{32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tab[5] = '{32'hA55A6997, 1'b1, 1'b1, 1'b0, 32'hA55A6997};
    tab[6] = '{TRAIN,        1'b1, 1'b0, 1'b1, 32'hA55A6997};
    tab[7] = '{32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
    tab[8] = '{TRAIN,        1'b1, 1'b0, 1'b1, 32'h00000000};
    tab[9] = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF};
    fill_train();
    for (int i = 0; i < 10; i++) strm[8+i] = tab[i];
    model_cmd = 32'hFFFFFFFF;
    for (int i = 18; i < 74; i++) begin
      w = (i >= 58 || $urandom_range(0, 3) == 0) ? TRAIN : $urandom();
      strm[i].word = w; strm[i].chk = 1'b1;
      strm[i].tr = (w == TRAIN); strm[i].cv = (w != TRAIN);
      if (w != TRAIN) model_cmd = w;
      strm[i].cmd = model_cmd;
    end
    do_reset(0);
    sb_on = 1'b1; lk_on = 1'b1; lock_cyc = 65;
    run(532);
    chk("main_no_bitslip", 32'(slips), 32'd0);
    chk("main_slip_count", 32'(slip_count), 32'd0);

    sb_on = 1'b0; exp_q.delete();
    c = cyc; relock = 1'b1; lock_cyc = first_end(c) + 58;
    step();
    relock = 1'b0;
    chk("relock_slip_count", 32'(slip_count), 32'd0);
    chk("relock_cmd_kept", command, model_cmd);
    run(30);

    c = cyc; rst = 1'b1; lock_cyc = first_end(c + 8) + 58;
    step();
    check_zero("midverify_reset");
    rst = 1'b0;
    run(lock_cyc + 10 - cyc);
    chk("rerun_no_bitslip", 32'(slips), 32'd0);

    // rotated streams need as many slips as the rotation
    for (int r = 1; r <= 3; r++) begin
      fill_train();
      do_reset((4 - r) % 4);
      t = 0;
      while (!locked && t < 400) begin step(); t++; end
      chk("slip_lock_reached", 32'(locked), 32'd1);
      chk("slip_pulses", 32'(slips), 32'(r));
      chk("slip_count", 32'(slip_count), 32'(r));
      if (slip_cyc.size() > 0) chk("slip_first", 32'(slip_cyc[0]), 32'd16);
      for (int k = 1; k < slip_cyc.size(); k++)
        chk("slip_spacing", 32'(slip_cyc[k] - slip_cyc[k-1]), 32'd20);
      if (r == 3) begin
        relock = 1'b1;
        step();
        relock = 1'b0;
        chk("relock_clears_count", 32'(slip_count), 32'd0);
        chk("relock_drops_lock", 32'(locked), 32'd0);
      end
    end

    // stream joined mid-word: no slips, sync with train two cycles after word end
    fill_train();
    for (int i = 9; i < 40; i++) begin strm[i].chk = 1'b1; strm[i].tr = 1'b1; end
    do_reset(12);
    sb_on = 1'b1; lk_on = 1'b1; lock_cyc = 70;
    run(180);
    chk("offset_no_bitslip", 32'(slips), 32'd0);
    chk("offset_slip_count", 32'(slip_count), 32'd0);

    // corrupted word during verify restarts the lock count without slipping
    fill_train();
    strm[4].word = 32'hA55A6997;
    do_reset(0);
    lk_on = 1'b1; lock_cyc = 105;
    run(120);
    chk("verify_fail_no_bitslip", 32'(slips), 32'd0);
    chk("verify_fail_slip_count", 32'(slip_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/surf_cin_decoder.md
Name: surf_cin_decoder

Overview:
SURF-side receiver for the CIN command link driven by the TURFIO. It takes 4-bit ISERDES nibbles at sysclk, finds the 32-bit word boundary by hunting for the training pattern, and requests ISERDES bitslips when no alignment is found. Once locked, it emits one 32-bit command word plus a local sync pulse every 8 sysclk cycles. It sits between the SURF CIN ISERDES and the SURF command/trigger logic.

Parameters:
TRAIN_SEQUENCE, 32'hA55A6996, training word sent by TURFIO while its train control is set.
LOCK_COUNT, 8, consecutive aligned training words required to declare lock (2..15).
BITSLIP_WAIT, 3, idle cycles after a bitslip pulse before hunting resumes (1..15).
HUNT_LIMIT, 16, cycles without a training match before a bitslip is issued.

Ports:
sysclk_i  input  1  system clock; all logic in this domain.
rst_i  input  1  synchronous active-high reset.
cin_data_i  input  4  ISERDES nibble, valid every cycle; bit 3 is the earliest-received bit.
relock_i  input  1  one-cycle request to drop lock and re-hunt.
bitslip_o  output  1  one-cycle bitslip request to ISERDES.
locked_o  output  1  word alignment established.
command_o  output  32  last received non-training word.
command_valid_o  output  1  one-cycle strobe; command_o is new.
train_o  output  1  one-cycle strobe; training word received while locked.
sync_o  output  1  one-cycle strobe at each word boundary while locked.
bitslip_count_o  output  3  bitslips issued since reset/relock; wraps at 8.

Behaviour:
- Shift register: every cycle, shreg <= {shreg[27:0], cin_data_i}. The first nibble of a word ends up in [31:28]. match = (shreg == TRAIN_SEQUENCE), combinational on the registered shreg.
- Phase counter: 3 bits, increments mod 8 in VERIFY and LOCKED. A word boundary occurs when phase==0.
- Reset (rst_i): state=HUNT. All outputs are 0: command_o=0, locked_o=0, bitslip_o=0, strobes=0, bitslip_count_o=0. shreg, hunt timer and match counter are cleared.
- HUNT:
  - hunt timer increments each cycle.
  - On match: phase<=1, match_cnt<=1, go to VERIFY. The matching cycle is boundary 0.
  - Otherwise, when the timer reaches HUNT_LIMIT-1: assert bitslip_o for one cycle, increment bitslip_count_o, clear the timer, go to SLIPWAIT.
  - match has priority over the timer expiring in the same cycle.
- SLIPWAIT: hold for BITSLIP_WAIT cycles, ignoring match, then go to HUNT with the timer at 0.
- VERIFY: at each phase==0:
  - match: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked_o=1 on the same edge.
  - mismatch: go to HUNT with the timer cleared. No bitslip is issued.
- LOCKED: at each phase==0, on the following edge:
  - sync_o=1 and command_o<=shreg;
  - if shreg==TRAIN_SEQUENCE: train_o=1 and command_valid_o=0, and command_o keeps its previous value (training words are not latched);
  - otherwise command_valid_o=1.
  - Lock is held until rst_i or relock_i; command contents are never checked for errors.
- Latency: last nibble of a word presented on cin_data_i in cycle n -> shreg holds the word in n+1 -> command_valid_o/train_o/sync_o high in n+2, with command_o valid in that same cycle.
- relock_i, from any state: go to HUNT; locked_o=0 next cycle; bitslip_count_o cleared; command_o retained; timers cleared.
- Priority: rst_i over relock_i over normal operation.
- Strobes never assert outside LOCKED. command_valid_o and train_o are mutually exclusive; sync_o accompanies each of them.
- A false match on partially slipped data is caught in VERIFY. The next real alignment is then found within one HUNT pass plus up to 3 further slips; a 4-bit bitslip cycle covers every bit phase.

Test Plan:
1. Reset, then drive repeating nibbles A,5,5,A,6,9,9,6 aligned -> first match detected; locked_o rises 8 words later (64 cycles ±1); bitslip_o never asserts; train_o pulses every 8 cycles thereafter; command_valid_o stays 0.
2. Same stream rotated by 1..3 bits through an ISERDES bitslip model -> bitslip_o pulses spaced HUNT_LIMIT+BITSLIP_WAIT+1 apart until aligned; lock is achieved with bitslip_count_o equal to the rotation needed (mod 4).
3. Training stream starting at nibble 3 of a word -> lock with zero bitslips; sync_o is coincident with train_o, exactly 2 cycles after each word's last nibble.
4. While locked, send one word 0x12345678 between training words -> command_valid_o high for exactly one cycle with command_o=0x12345678, 2 cycles after nibble 8; the next training word gives train_o=1 and command_o stays 0x12345678.
5. During VERIFY (match_cnt=4), corrupt one word to 0xA55A6997 -> return to HUNT, no bitslip, locked_o stays 0; relock completes after 8 further clean words.
6. Assert relock_i while locked -> locked_o=0 and bitslip_count_o=0 next cycle, re-lock follows. Assert rst_i mid-VERIFY -> all outputs 0 on the next edge and the hunt restarts.
